multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle RV32I core; sequences one shared ALU, one unified instruction/data memory port and the IR/PC/ALUOut/Data registers over several cycles per instruction.
- Sits beside the multi-cycle datapath. Consumes the IR fields and the ALU flags, and drives every datapath enable and mux select.
- Supports memory wait states through a ready handshake, plus a watchdog.

---
 rtl/multicycle_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main sequencing FSM for the multi-cycle RV32I core.
// Drives datapath enables/selects from the current state and IR fields,
// waits on the shared memory port via mem_ready, and traps on illegal
// opcodes or on a memory request that stays unanswered for MEM_TIMEOUT cycles.
//
// Debug state encoding (state output):
//   0 FETCH  1 DECODE  2 MEMADR  3 MEMREAD  4 MEMWB  5 MEMWRITE  6 EXECR
//   7 EXECI  8 ALUWB   9 BRANCH 10 JAL     11 JALR  12 LUI      13 AUIPC 14 TRAP
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Counter holds completed wait cycles; the trap fires on the wait cycle
  // that would bring the count to MEM_TIMEOUT.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic WD_EN = (MEM_TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            illegal_q, illegal_d;

  logic            wait_st, wd_hit, br_taken, br_bad;
  logic            mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, done_c;

  // ALU op for register/immediate arithmetic; immediates ignore funct7b5
  // except to pick the arithmetic right shift.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic is_imm);
    logic [3:0] r;
    case (f3)
      3'b000:  r = (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      OP_STORE:         imm_src = 3'b001;
      OP_BRANCH:        imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  // Branch condition from funct3; 010/011 are not branch encodings.
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign wd_hit  = WD_EN && wait_st && !mem_ready && (wait_cnt_q == WAIT_LAST);

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(funct3, funct7b5, 1'b0);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(funct3, funct7b5, 1'b1);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        if (br_bad) begin
          state_d = S_TRAP;
        end else begin
          pc_write_c = br_taken;
          done_c     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
    if (wd_hit) state_d = S_TRAP;
  end

  // Wait counter runs only while parked in a memory state without ready.
  always_comb begin
    wait_cnt_d = '0;
    if (wait_st && !mem_ready && (state_d == state_q)) wait_cnt_d = wait_cnt_q + CW'(1);
  end

  assign illegal_d = illegal_q || (state_d == S_TRAP);

  // State, watchdog count and sticky trap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  // Enables are held low during reset so an in-flight request is dropped at once.
  assign mem_req    = rst_n & mem_req_c;
  assign mem_write  = rst_n & mem_write_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign instr_done = rst_n & done_c;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT = 4).
module tb_multicycle_controller;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
                         TRAP = 4'd14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       instr_done, illegal;
  logic [3:0] state;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int irw  = 0;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                           input logic l, input logic lu, input logic exp_pc);
    op = 7'b1100011; funct3 = f3; zero = z; lt = l; ltu = lu; mem_ready = 1'b1;
    cyc = 0;
    settle(); chk({tag, "_fetch"}, state, FETCH);
    tick(); settle(); chk({tag, "_dec_imm"}, imm_src, 3'b010);
    tick(); settle();
    chk({tag, "_state"}, state, BRANCH);
    chk({tag, "_pcw"}, pc_write, exp_pc);
    chk({tag, "_aluc"}, alu_control, 4'b0001);
    chk({tag, "_done"}, instr_done, 1'b1);
    tick(); settle();
    chk({tag, "_back"}, state, FETCH);
    chk({tag, "_cycles"}, cyc, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", state, FETCH);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_srcb", alu_src_b, 2'b10);
    tick(); rst_n = 1'b1; settle();

    // add, zero-wait: FETCH DECODE EXECR ALUWB
    chk("add_fetch_req", mem_req, 1'b1);
    chk("add_fetch_irw", ir_write, 1'b1);
    chk("add_fetch_res", result_src, 2'b10);
    tick(); settle();
    chk("add_dec", state, DECODE);
    chk("add_dec_a", alu_src_a, 2'b01);
    tick(); settle();
    chk("add_execr", state, EXECR);
    chk("add_aluc", alu_control, 4'b0000);
    chk("add_srcab", {alu_src_a, alu_src_b}, 4'b1000);
    tick(); settle();
    chk("add_aluwb", state, ALUWB);
    chk("add_regw", reg_write, 1'b1);
    chk("add_done", instr_done, 1'b1);
    tick(); settle();

    // sub (R) and addi with funct7b5 = 1 (still add)
    funct7b5 = 1'b1;
    tick(); tick(); settle();
    chk("sub_aluc", alu_control, 4'b0001);
    tick(); tick(); op = 7'b0010011; settle();
    tick(); tick(); settle();
    chk("addi_state", state, EXECI);
    chk("addi_f7_aluc", alu_control, 4'b0000);
    chk("addi_srcb", alu_src_b, 2'b01);
    funct3 = 3'b101; settle();
    chk("srai_aluc", alu_control, 4'b1001);
    tick(); tick(); settle();
    funct7b5 = 1'b0;

    // lw with 3 fetch waits and 2 read waits -> 10 cycles
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0; cyc = 0; irw = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("ld_fwait_req", mem_req, 1'b1); irw += int'(ir_write); tick();
    end
    mem_ready = 1'b1; settle(); irw += int'(ir_write); tick();
    settle(); chk("ld_dec", state, DECODE); irw += int'(ir_write); tick();
    settle(); chk("ld_memadr", state, MEMADR); chk("ld_adr_ab", {alu_src_a, alu_src_b}, 4'b1001);
    tick(); mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("ld_rwait", {state, mem_req, adr_src}, {MEMREAD, 2'b11}); tick();
    end
    mem_ready = 1'b1; settle(); tick();
    settle();
    chk("ld_memwb", state, MEMWB);
    chk("ld_res", result_src, 2'b01);
    chk("ld_regw", reg_write, 1'b1);
    chk("ld_done", instr_done, 1'b1);
    tick(); settle();
    chk("ld_cycles", cyc, 10);
    chk("ld_irw_pulses", irw, 1);
    chk("ld_back", state, FETCH);

    // branches
    do_branch("beq_t", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    do_branch("bne_nt", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    do_branch("bltu_t", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);

    // jalr: FETCH DECODE JALR JAL ALUWB
    op = 7'b1100111; funct3 = 3'b000;
    tick(); settle(); chk("jalr_dec_imm", imm_src, 3'b000);
    tick(); settle();
    chk("jalr_state", state, JALR);
    chk("jalr_ab", {alu_src_a, alu_src_b}, 4'b1001);
    tick(); settle();
    chk("jal_state", state, JAL);
    chk("jal_pcw", pc_write, 1'b1);
    chk("jal_res", result_src, 2'b00);
    tick(); settle();
    chk("jalr_wb", {state, reg_write, result_src}, {ALUWB, 3'b100});
    tick(); settle();

    // reset in the middle of a load wait drops the request
    op = 7'b0000011;
    tick(); tick(); tick(); mem_ready = 1'b0; settle();
    chk("midwait_req", mem_req, 1'b1);
    rst_n = 1'b0; settle();
    chk("midwait_rst_req", mem_req, 1'b0);
    chk("midwait_rst_state", state, FETCH);
    tick(); rst_n = 1'b1; mem_ready = 1'b1; settle();

    // illegal opcode traps after DECODE and sticks until reset
    op = 7'b1111111;
    tick(); settle(); chk("ill_dec_flag", illegal, 1'b0);
    tick(); settle();
    chk("ill_state", state, TRAP);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_enables", {mem_req, ir_write, pc_write, reg_write, mem_write}, 5'b0);
    tick(); tick(); settle();
    chk("ill_sticky", {state, illegal}, {TRAP, 1'b1});
    rst_n = 1'b0; settle();
    chk("ill_rst_flag", illegal, 1'b0);
    tick(); rst_n = 1'b1; settle();
    chk("ill_rst_state", state, FETCH);

    // watchdog: sw stuck in MEMWRITE for 4 cycles -> TRAP
    op = 7'b0100011; funct3 = 3'b010;
    tick(); tick(); tick(); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("wd_wait", {state, mem_req, mem_write}, {MEMWRITE, 2'b11}); tick();
    end
    settle();
    chk("wd_trap", state, TRAP);
    chk("wd_req_off", mem_req, 1'b0);
    chk("wd_flag", illegal, 1'b1);
    rst_n = 1'b0; settle(); tick(); rst_n = 1'b1; mem_ready = 1'b1;

    // ready arrives on the 4th wait cycle -> completes, no trap
    tick(); tick(); tick(); mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    mem_ready = 1'b1; settle();
    chk("wd_edge_done", {state, instr_done}, {MEMWRITE, 1'b1});
    tick(); settle();
    chk("wd_edge_state", state, FETCH);
    chk("wd_edge_flag", illegal, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
